// File: rtl/fnd_pkg.sv
// Shared types and helpers for the 4-digit FND scan controller.
package fnd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } fnd_state_e;

  localparam logic [3:0] FND_BLANK_CODE = 4'hf;
  localparam int         FND_DIGITS     = 4;

  // A digit above 0 is suppressed when it and every more-significant nibble are zero.
  function automatic logic [3:0] fnd_display_nibble(
    input logic [15:0] value,
    input logic [1:0]  idx,
    input logic        lzb
  );
    logic [15:0] upper;
    upper = value >> {idx, 2'b00};
    if (lzb && (idx != 2'd0) && (upper == 16'h0000)) begin
      return FND_BLANK_CODE;
    end
    return upper[3:0];
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Digit-slot counter: flags the last cycle of a slot and the anti-ghosting blank window.
module fnd_slot_timer #(
  parameter int P_SCAN_DIV = 100000,
  parameter int P_BLANK    = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_slotEnd,
  output logic o_blankPhase,
  output logic o_blankLast
);

  localparam int                   LP_CNT_W      = $clog2(P_SCAN_DIV);
  localparam logic [LP_CNT_W-1:0]  LP_LAST       = LP_CNT_W'(P_SCAN_DIV - 1);
  localparam logic [LP_CNT_W-1:0]  LP_BLANK      = LP_CNT_W'(P_BLANK);
  localparam logic [LP_CNT_W-1:0]  LP_BLANK_LAST = LP_CNT_W'(P_BLANK - 1);
  localparam logic [LP_CNT_W-1:0]  LP_ONE        = LP_CNT_W'(1);

  logic [LP_CNT_W-1:0] r_slotCnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slotCnt <= '0;
    end else if (o_slotEnd) begin
      r_slotCnt <= '0;
    end else begin
      r_slotCnt <= r_slotCnt + LP_ONE;
    end
  end

  assign o_slotEnd    = (r_slotCnt == LP_LAST);
  assign o_blankPhase = (r_slotCnt < LP_BLANK);
  assign o_blankLast  = (r_slotCnt == LP_BLANK_LAST);

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: frame-synchronous BCD latch, digit scanning,
// anti-ghosting blanking and leading-zero suppression with registered outputs.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int P_SCAN_DIV = 100000,
  parameter int P_BLANK    = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic        i_load,
  input  logic        i_lzb,
  output logic [3:0]  o_bcd,
  output logic [3:0]  o_digit_sel,
  output logic        o_frame
);

  logic w_slotEnd;
  logic w_blankPhase;
  logic w_blankLast;

  fnd_slot_timer #(
    .P_SCAN_DIV (P_SCAN_DIV),
    .P_BLANK    (P_BLANK)
  ) u_slotTimer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .o_slotEnd    (w_slotEnd),
    .o_blankPhase (w_blankPhase),
    .o_blankLast  (w_blankLast)
  );

  fnd_state_e  r_state;
  fnd_state_e  w_stateNext;
  logic [1:0]  r_idx;
  logic [1:0]  w_idxNext;
  logic [15:0] r_shadow;
  logic [15:0] w_shadowNext;
  logic [15:0] r_pending;
  logic        r_pend;
  logic        w_frameEdge;

  assign w_frameEdge = w_slotEnd && (r_idx == 2'd3);

  // Outputs are built from next-state values so they change on the same edge as state/idx.
  always_comb begin
    w_stateNext  = r_state;
    w_idxNext    = r_idx;
    w_shadowNext = r_shadow;
    case (r_state)
      BLANK:   w_stateNext = (w_blankPhase && !w_blankLast) ? BLANK : SHOW;
      SHOW:    w_stateNext = w_slotEnd ? BLANK : SHOW;
      default: w_stateNext = BLANK;
    endcase
    if (w_slotEnd) begin
      w_idxNext = r_idx + 2'd1;
    end
    if (w_frameEdge) begin
      if (i_load) begin
        w_shadowNext = i_bcd;
      end else if (r_pend) begin
        w_shadowNext = r_pending;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= BLANK;
      r_idx       <= 2'd0;
      r_shadow    <= 16'h0000;
      r_pending   <= 16'h0000;
      r_pend      <= 1'b0;
      o_digit_sel <= 4'b1111;
      o_bcd       <= FND_BLANK_CODE;
      o_frame     <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_idx    <= w_idxNext;
      r_shadow <= w_shadowNext;
      if (w_frameEdge) begin
        r_pend <= 1'b0;
      end else if (i_load) begin
        r_pending <= i_bcd;
        r_pend    <= 1'b1;
      end
      o_frame <= w_frameEdge;
      if (w_stateNext == SHOW) begin
        o_digit_sel <= ~(4'b0001 << w_idxNext);
        o_bcd       <= fnd_display_nibble(w_shadowNext, w_idxNext, i_lzb);
      end else begin
        o_digit_sel <= 4'b1111;
        o_bcd       <= FND_BLANK_CODE;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (P_SCAN_DIV=8, P_BLANK=2): per-cycle
// reference model, a vector table of display scenarios, and corner-case sequences.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rReset;
  logic        rLoad;
  logic        rLzb;
  logic [15:0] rBcd;
  logic [3:0]  oBcd;
  logic [3:0]  oDigitSel;
  logic        oFrame;

  int checks = 0;
  int errors = 0;

  int          n = 0;
  logic [15:0] mShadow = 16'h0;
  logic [15:0] mPending = 16'h0;
  bit          mPend = 1'b0;
  bit          modelOn = 1'b0;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .P_SCAN_DIV (8),
    .P_BLANK    (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rReset),
    .i_bcd       (rBcd),
    .i_load      (rLoad),
    .i_lzb       (rLzb),
    .o_bcd       (oBcd),
    .o_digit_sel (oDigitSel),
    .o_frame     (oFrame)
  );

  function automatic logic [3:0] refNibble(logic [15:0] v, int k, logic lzb);
    int          hi;
    logic [15:0] t;
    hi = -1;
    t  = v;
    for (int j = 0; j < 4; j++) begin
      if (t[3:0] != 4'h0) hi = j;
      t = t >> 4;
    end
    t = v >> (4 * k);
    if (lzb && k > 0 && k > hi) return 4'hf;
    return t[3:0];
  endfunction

  task automatic checkOutput(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s n=%0d actual=%h expected=%h", name, n, act, exp);
    end
  endtask

  // One clock: the model follows the frame/slot arithmetic and every output is compared.
  task automatic tick();
    int         k;
    bit         show;
    logic [3:0] expSel;
    logic [3:0] expBcd;
    logic       expFrame;
    @(posedge clk);
    #1;
    if (rReset) begin
      n = 0; mShadow = 16'h0; mPending = 16'h0; mPend = 1'b0; modelOn = 1'b1;
    end else if (modelOn) begin
      n++;
      if (n % 32 == 0) begin
        if (rLoad) begin
          mShadow = rBcd; mPend = 1'b0;
        end else if (mPend) begin
          mShadow = mPending; mPend = 1'b0;
        end
      end else if (rLoad) begin
        mPending = rBcd; mPend = 1'b1;
      end
    end
    if (modelOn) begin
      k        = (n / 8) % 4;
      show     = (n % 8) >= 2;
      expSel   = show ? (4'hf & ~(4'h1 << k)) : 4'hf;
      expBcd   = show ? refNibble(mShadow, k, rLzb) : 4'hf;
      expFrame = !rReset && n > 0 && (n % 32 == 0);
      checkOutput("model sel", oDigitSel, expSel);
      checkOutput("model bcd", oBcd, expBcd);
      checkOutput("model frame", {3'b0, oFrame}, {3'b0, expFrame});
    end
    rLoad = 1'b0;
  endtask

  task automatic applyStimulus(logic load, logic [15:0] bcd, logic lzb);
    rLoad = load;
    rBcd  = bcd;
    rLzb  = lzb;
    tick();
  endtask

  task automatic waitFrame();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oFrame === 1'b1) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL waitFrame timeout actual=no_frame expected=frame_pulse");
  endtask

  task automatic waitSel(int k);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oDigitSel === want) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL waitSel timeout actual=%b expected=%b", oDigitSel, want);
  endtask

  typedef struct {
    bit          twoLoads;
    logic [15:0] first;
    logic [15:0] bcd;
    logic        lzb;
    logic [15:0] expDigits;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rReset = 1'b1;
    rLoad  = 1'b0;
    rLzb   = 1'b0;
    rBcd   = 16'h0;

    vecs[0] = '{1'b0, 16'h0000, 16'h1234, 1'b0, 16'h1234};
    vecs[1] = '{1'b1, 16'h1111, 16'h5678, 1'b0, 16'h5678};
    vecs[2] = '{1'b0, 16'h0000, 16'h0070, 1'b1, 16'hff70};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hfff0};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 16'ha05f, 1'b1, 16'ha05f};
    vecs[6] = '{1'b0, 16'h0000, 16'h0a00, 1'b1, 16'hfa00};
    vecs[7] = '{1'b0, 16'h0000, 16'h0100, 1'b0, 16'h0100};
    vecs[8] = '{1'b0, 16'h0000, 16'h0001, 1'b1, 16'hfff1};

    // Reset and idle scan.
    tick();
    checkOutput("reset sel", oDigitSel, 4'b1111);
    checkOutput("reset bcd", oBcd, 4'hf);
    checkOutput("reset frame", {3'b0, oFrame}, 4'h0);
    rReset = 1'b0;
    tick();
    checkOutput("idle blank2 sel", oDigitSel, 4'b1111);
    tick();
    checkOutput("first show sel", oDigitSel, 4'b1110);
    checkOutput("first show bcd", oBcd, 4'h0);
    waitFrame();
    checkOutput("frame at 32", (n == 32) ? 4'h1 : 4'h0, 4'h1);
    waitFrame();
    checkOutput("frame at 64", (n == 64) ? 4'h1 : 4'h0, 4'h1);

    for (int r = 0; r < 9; r++) begin
      rLzb = vecs[r].lzb;
      tick();
      if (vecs[r].twoLoads) begin
        applyStimulus(1'b1, vecs[r].first, vecs[r].lzb);
        tick();
        tick();
      end
      applyStimulus(1'b1, vecs[r].bcd, vecs[r].lzb);
      waitFrame();
      for (int k = 0; k < 4; k++) begin
        logic [15:0] e;
        e = vecs[r].expDigits >> (4 * k);
        waitSel(k);
        checkOutput($sformatf("table row%0d digit%0d", r, k), oBcd, e[3:0]);
      end
    end

    // Load exactly on the frame-boundary cycle goes straight to the display.
    rLzb = 1'b0;
    for (int i = 0; i < 40 && (n % 32) != 31; i++) tick();
    applyStimulus(1'b1, 16'h9999, 1'b0);
    checkOutput("boundary load frame", {3'b0, oFrame}, 4'h1);
    waitSel(0);
    checkOutput("boundary load digit0", oBcd, 4'h9);

    // Reset during SHOW of digit 2 discards both shadow and a pending value.
    applyStimulus(1'b1, 16'h4321, 1'b0);
    waitFrame();
    waitSel(2);
    checkOutput("pre-reset digit2", oBcd, 4'h3);
    applyStimulus(1'b1, 16'h5555, 1'b0);
    rReset = 1'b1;
    tick();
    checkOutput("midslot reset sel", oDigitSel, 4'b1111);
    checkOutput("midslot reset bcd", oBcd, 4'hf);
    rReset = 1'b0;
    waitSel(0);
    checkOutput("post-reset digit0", oBcd, 4'h0);
    waitFrame();
    waitSel(3);
    checkOutput("pending discarded digit3", oBcd, 4'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      for (int j = 0; j < 4; j++) begin
        v[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) rLzb = ~rLzb;
      if ($urandom_range(0, 399) == 0) begin
        rReset = 1'b1;
        tick();
        rReset = 1'b0;
      end else begin
        applyStimulus(($urandom_range(0, 19) == 0), v, rLzb);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Time-multiplexed scan controller for the 4-digit common-anode FND display. It latches a 4-digit BCD value, tear-free, at frame boundaries. It cycles the digit selects and presents one BCD nibble per slot to the downstream BCD-to-FND font decoder. It sits between the application counters/FSMs (timer, motor-speed readout) and the font decoder, and owns all display timing, anti-ghosting blanking and leading-zero suppression.

## Interface
Parameters:
- P_SCAN_DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ P_BLANK+1.
- P_BLANK, 1000: cycles at the start of each slot with all digits off (anti-ghosting); legal range ≥ 1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_bcd  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- i_load  in  1  single-cycle strobe; captures i_bcd.
- i_lzb  in  1  leading-zero blanking enable (level, sampled every cycle).
- o_bcd  out  4  nibble to the font decoder; 4'hf = blank.
- o_digit_sel  out  4  digit anodes, active-low, one-hot-low or all-ones.
- o_frame  out  1  one-cycle pulse on the cycle digit index wraps 3→0.

## Operation
- States: BLANK, SHOW. A slot is P_SCAN_DIV cycles: the first P_BLANK cycles are BLANK, the rest are SHOW. At slot end, digit index idx advances modulo 4 and the state returns to BLANK.
- BLANK: o_digit_sel = 4'b1111, o_bcd = 4'hf.
- SHOW: o_digit_sel has bit idx low and all others high; o_bcd = displayed nibble of shadow[idx].
- Load path: i_load copies i_bcd into a pending register and sets pend. On the frame-boundary cycle (idx 3→0) with pend set, pending moves to shadow and pend clears. Repeated loads within a frame overwrite pending: last wins.
- Simultaneous i_load and frame boundary: i_bcd goes directly into shadow and pend clears. The new value is visible from digit 0 of the next frame.
- Leading-zero blanking (i_lzb=1): digit k > 0 is shown as 4'hf when shadow nibbles k..3 are all 4'h0. Digit 0 is never suppressed, so 0000 shows "0".
- Nibbles 4'ha–4'hf pass through unchanged (4'ha gives the dot-only glyph). The decoder blanks codes above 4'ha.
- o_frame asserts on the same edge on which idx becomes 0.

## Timing
- Reset values: state BLANK, idx 0, slot counter 0, shadow 16'h0000, pending 0, pend 0, o_digit_sel 4'b1111, o_bcd 4'hf, o_frame 0.
- All outputs are registered and change on the same edge as the state/idx they reflect; there is no combinational input→output path.
- The first SHOW after reset begins P_BLANK cycles after reset deassert, on digit 0 with value 0.
- Frame period is 4·P_SCAN_DIV cycles. Worst-case i_load-to-display latency is 4·P_SCAN_DIV + P_BLANK cycles.
- Reset mid-slot: all state returns to reset values on the next edge; a pending value is discarded.
- The slot counter is ceil(log2(P_SCAN_DIV)) bits. It wraps to 0 at P_SCAN_DIV-1; no free-running overflow.

## Structure
- Package fnd_pkg: state enum {BLANK, SHOW}, constant FND_BLANK_CODE = 4'hf, FND_DIGITS = 4.
- Sub-module fnd_slot_timer: parameterised slot counter. Outputs slot_end and blank_phase (counter < P_BLANK).
- The top level holds the FSM, idx, pending/shadow registers, LZB logic and output registers.

## Test plan
All scenarios use P_SCAN_DIV=8, P_BLANK=2.
- Reset and idle: after reset, o_digit_sel=1111 and o_bcd=f for 2 cycles; then digit 0 shows 0 with sel=1110 for 6 cycles; sel sequence is 1110, 1101, 1011, 0111; o_frame pulses every 32 cycles.
- Load 16'h1234 mid-frame → unchanged until the next o_frame; then digits 0–3 show 4, 3, 2, 1.
- Two loads in one frame (16'h1111, then 16'h5678) → next frame shows 8, 7, 6, 5 only.
- i_load with 16'h9999 on the frame-boundary cycle → digit 0 of the following frame shows 9.
- i_lzb=1 with 16'h0070 → digits 3 and 2 show f, digit 1 shows 7, digit 0 shows 0. i_lzb=1 with 16'h0000 → digits 3–1 show f, digit 0 shows 0.
- Assert i_reset during SHOW of digit 2 with 16'h4321 loaded → next edge gives sel=1111 and o_bcd=f; after release, digit 0 shows 0 (shadow cleared).
